// File: rtl/w5500_spi_responder.sv
`timescale 1ns/1ps
// w5500_spi_responder
//   SPI mode-0 slave terminating W5500-style frames: 16-bit address, control
//   byte {bsb[4:0], rwb, om[1:0]}, then data bytes. Writes become one-clk
//   register-bank strobes; reads fetch from the bank and shift out on miso.
//   All SPI pins are oversampled in the clk domain (clk >= 8x sck).
// Ports:
//   clk, rstn             system clock, async active-low reset
//   sck, cs_n, mosi       SPI inputs (asynchronous to clk)
//   miso, miso_oe         SPI output and its enable
//   wr_en/addr/bsb/data   write strobe, held until the next strobe
//   rd_req/addr/bsb       read request; rd_data valid the clk after rd_req
//   frame_done/abort      one-clk end-of-frame status pulses
module w5500_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sck,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [4:0]  wr_bsb,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    output logic [4:0]  rd_bsb,
    input  logic [7:0]  rd_data,
    output logic        frame_done,
    output logic        frame_abort
);

    typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, CTRL, DATA} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_q;
    logic                   sck_s, cs_s, mosi_s, sck_rise, sck_fall;

    // Synchronizers reset to 0 so any 1 seen on cs_s really came from the pin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_q     <= sck_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx, tx;
    logic [15:0] addr;
    logic [4:0]  bsb;
    logic        rwb;
    logic [1:0]  om;
    logic [2:0]  dcnt;
    logic        rd_pend;
    logic        armed;     // cs_n seen high since reset; gates frame start

    logic [7:0] rx_byte;
    logic       byte_done, in_lim, in_lim_nx, clean_end;
    logic [2:0] lim;

    always_comb begin
        rx_byte   = {rx[6:0], mosi_s};
        byte_done = sck_rise && (bit_cnt == 3'd7);
        case (om)
            2'd1:    lim = 3'd1;
            2'd2:    lim = 3'd2;
            default: lim = 3'd4;
        endcase
        in_lim    = (om == 2'd0) || (dcnt < lim);
        in_lim_nx = (om == 2'd0) || ((dcnt + 3'd1) < lim);
        // A byte completing in the same clk as cs_n rising counts as whole.
        clean_end = ((state == DATA) &&
                     (sck_rise ? (bit_cnt == 3'd7) : (bit_cnt == 3'd0))) ||
                    ((state == CTRL) && byte_done);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            addr        <= '0;
            bsb         <= '0;
            rwb         <= 1'b0;
            om          <= '0;
            dcnt        <= '0;
            rd_pend     <= 1'b0;
            armed       <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_bsb      <= '0;
            wr_data     <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            rd_bsb      <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            rd_req      <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            rd_pend     <= rd_req;
            miso_oe     <= armed & ~cs_s;
            if (cs_s) armed <= 1'b1;

            if (state == IDLE) begin
                miso    <= 1'b0;
                bit_cnt <= '0;
                dcnt    <= '0;
                if (armed && !cs_s) state <= ADDR_HI;
            end else begin
                if (sck_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx      <= rx_byte;
                end
                if (byte_done) begin
                    case (state)
                        ADDR_HI: begin
                            addr[15:8] <= rx_byte;
                            state      <= ADDR_LO;
                        end
                        ADDR_LO: begin
                            addr[7:0] <= rx_byte;
                            state     <= CTRL;
                        end
                        CTRL: begin
                            bsb   <= rx_byte[7:3];
                            rwb   <= rx_byte[2];
                            om    <= rx_byte[1:0];
                            state <= DATA;
                            if (!rx_byte[2]) begin
                                rd_req  <= 1'b1;
                                rd_addr <= addr;
                                rd_bsb  <= rx_byte[7:3];
                            end
                        end
                        default: begin  // DATA
                            addr <= addr + 16'd1;
                            if (in_lim) begin
                                dcnt <= dcnt + 3'd1;
                                if (rwb) begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= addr;
                                    wr_bsb  <= bsb;
                                    wr_data <= rx_byte;
                                end else if (in_lim_nx) begin
                                    rd_req  <= 1'b1;
                                    rd_addr <= addr + 16'd1;
                                    rd_bsb  <= bsb;
                                end
                            end
                        end
                    endcase
                end
                if (sck_fall) begin
                    miso <= (state == DATA) && !rwb && in_lim && tx[7];
                    tx   <= {tx[6:0], 1'b0};
                end
                if (cs_s) begin
                    state <= IDLE;
                    miso  <= 1'b0;
                    if (clean_end) frame_done  <= 1'b1;
                    else           frame_abort <= 1'b1;
                end
            end
            // Fetched byte lands after any shift in the same clk.
            if (rd_pend) tx <= rd_data;
        end
    end

endmodule

// File: tb/tb_w5500_spi_responder.sv
`timescale 1ns/1ps
module tb_w5500_spi_responder;

    logic        clk = 1'b0;
    logic        rstn, sck, cs_n, mosi;
    logic        miso, miso_oe, wr_en, rd_req, frame_done, frame_abort;
    logic [15:0] wr_addr, rd_addr;
    logic [4:0]  wr_bsb, rd_bsb;
    logic [7:0]  wr_data, rd_data;

    w5500_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_bsb(wr_bsb), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_bsb(rd_bsb), .rd_data(rd_data),
        .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    // Register bank stand-in: returns addr[7:0]+1 the clk after rd_req.
    always @(posedge clk) if (rd_req) rd_data <= rd_addr[7:0] + 8'd1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [28:0] exp_wr_q[$];   // {addr, bsb, data}
    logic [20:0] exp_rd_q[$];   // {addr, bsb}
    int          exp_fr_q[$];   // 1 = done, 2 = abort

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: unexpected event, value %h", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_wr_q.size() == 0) unexpected("wr_en", {3'b0, wr_addr, wr_bsb, wr_data});
            else check("wr", {3'b0, wr_addr, wr_bsb, wr_data}, {3'b0, exp_wr_q.pop_front()});
        end
        if (rd_req) begin
            if (exp_rd_q.size() == 0) unexpected("rd_req", {11'b0, rd_addr, rd_bsb});
            else check("rd", {11'b0, rd_addr, rd_bsb}, {11'b0, exp_rd_q.pop_front()});
        end
        if (frame_done) begin
            if (exp_fr_q.size() == 0) unexpected("frame_done", 32'd1);
            else check("frame_end(done=1)", 32'd1, exp_fr_q.pop_front());
        end
        if (frame_abort) begin
            if (exp_fr_q.size() == 0) unexpected("frame_abort", 32'd2);
            else check("frame_end(abort=2)", 32'd2, exp_fr_q.pop_front());
        end
    end

    task automatic check_idle_outputs(input string name);
        check({name, " miso"},        miso, 0);
        check({name, " miso_oe"},     miso_oe, 0);
        check({name, " wr_en"},       wr_en, 0);
        check({name, " wr_addr"},     wr_addr, 0);
        check({name, " wr_bsb"},      wr_bsb, 0);
        check({name, " wr_data"},     wr_data, 0);
        check({name, " rd_req"},      rd_req, 0);
        check({name, " rd_addr"},     rd_addr, 0);
        check({name, " rd_bsb"},      rd_bsb, 0);
        check({name, " frame_done"},  frame_done, 0);
        check({name, " frame_abort"}, frame_abort, 0);
    endtask

    // sck = clk/8; mosi set while sck low, miso sampled just before the rise.
    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] mb);
        mb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            repeat (4) @(negedge clk);
            mb[7-i] = miso;
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic end_frame(input string name);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check({name, " miso after cs high"},    miso, 0);
        check({name, " miso_oe after cs high"}, miso_oe, 0);
    endtask

    // Bytes of v / em are taken MSB-first from the low n bytes.
    task automatic run_frame(input string name, input logic [63:0] v, input int n,
                             input logic [63:0] em);
        logic [7:0] mb;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            send_bits(v[8*(n-1-k) +: 8], 8, mb);
            check($sformatf("%s miso byte %0d", name, k), {24'b0, mb}, {24'b0, em[8*(n-1-k) +: 8]});
            if (k == 0) check({name, " miso_oe in frame"}, miso_oe, 1);
        end
        end_frame(name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] mb;
        rstn = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        // Variable-length write
        exp_wr_q.push_back({16'h0001, 5'd0, 8'hC0});
        exp_wr_q.push_back({16'h0002, 5'd0, 8'hA8});
        exp_wr_q.push_back({16'h0003, 5'd0, 8'h01});
        exp_wr_q.push_back({16'h0004, 5'd0, 8'h01});
        exp_fr_q.push_back(1);
        run_frame("varwr", 64'h00_0001_04C0_A801_01, 7, 64'h0);

        // Fixed-length write, OM=01: trailing byte ignored
        exp_wr_q.push_back({16'h001E, 5'd1, 8'h02});
        exp_fr_q.push_back(1);
        run_frame("fixwr", 64'h00_001E_0D02_55, 5, 64'h0);

        // Variable read: bytes 3A, 3B out; third fetch issued after byte two
        exp_rd_q.push_back({16'h0039, 5'd0});
        exp_rd_q.push_back({16'h003A, 5'd0});
        exp_rd_q.push_back({16'h003B, 5'd0});
        exp_fr_q.push_back(1);
        run_frame("varrd", 64'h00_0039_0000_00, 5, 64'h00_0000_003A_3B);

        // Address wrap
        exp_wr_q.push_back({16'hFFFF, 5'd0, 8'h11});
        exp_wr_q.push_back({16'h0000, 5'd0, 8'h22});
        exp_fr_q.push_back(1);
        run_frame("wrap", 64'hFF_FF04_1122, 5, 64'h0);

        // Abort after 3 bits of the first data byte, then a clean OM=01 write
        exp_fr_q.push_back(2);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(8'h00, 8, mb);
        send_bits(8'h2E, 8, mb);
        send_bits(8'h04, 8, mb);
        send_bits(8'hA0, 3, mb);
        end_frame("abort");
        exp_wr_q.push_back({16'h002E, 5'd0, 8'h00});
        exp_fr_q.push_back(1);
        run_frame("postabort", 64'h002E_0500, 4, 64'h0);

        // Reset during ADDR_LO, cs_n kept low: rest of frame must be ignored
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(8'h00, 8, mb);
        send_bits(8'h12, 4, mb);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("midreset");
        rstn = 1'b1;
        send_bits(8'h20, 4, mb);
        send_bits(8'h04, 8, mb);
        send_bits(8'hAB, 8, mb);
        end_frame("midreset");
        exp_wr_q.push_back({16'h0010, 5'd0, 8'h5A});
        exp_fr_q.push_back(1);
        run_frame("resume", 64'h0010_045A, 4, 64'h0);

        repeat (10) @(negedge clk);
        check("wr queue drained", exp_wr_q.size(), 0);
        check("rd queue drained", exp_rd_q.size(), 0);
        check("frame queue drained", exp_fr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
